// File: rtl/mem_manager_pkg.sv
// Shared types for the mem_manager Avalon write master: FSM state encoding
// and the byte-offset shift between byte addresses and word addresses.
package mem_manager_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wm_state_t;

  localparam int WM_BYTEENABLEWIDTH = 4;
  localparam int BYTE_SHIFT         = $clog2(WM_BYTEENABLEWIDTH);

endpackage

// File: rtl/wm_fifo.sv
// Synchronous show-ahead FIFO buffering user words for the write master.
// data_o always presents the head word; full_o is registered alongside the count.
module wm_fifo #(
  parameter int DATAWIDTH  = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [DATAWIDTH-1:0] data_i,
  input  logic                 pop_i,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          count_q, count_d;
  logic                 full_q;
  logic                 do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (PW+1)'(FIFO_DEPTH));
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/avalon_write_master.sv
// Avalon-MM single-word write master fed from a user FIFO.
// Optional beat counter output enabled by defining WRITE_MASTER_BEAT_COUNT_EN.
module avalon_write_master
  import mem_manager_pkg::*;
#(
  parameter int ADDRESSWIDTH    = 28,
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = DATAWIDTH / 8,
  parameter int FIFO_DEPTH      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_write_base,
  input  logic [ADDRESSWIDTH-1:0]    control_write_length,
  input  logic                       control_go,
  output logic                       control_done,
  input  logic                       user_write_buffer,
  input  logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_buffer_full,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_write,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  output logic [DATAWIDTH-1:0]       master_writedata,
  input  logic                       master_waitrequest
`ifdef WRITE_MASTER_BEAT_COUNT_EN
  ,
  output logic [31:0]                beat_count
`endif
);

  localparam logic [ADDRESSWIDTH-1:0] STEP = ADDRESSWIDTH'(BYTEENABLEWIDTH);

  wm_state_t                state_q, state_d;
  logic [ADDRESSWIDTH-1:0]  addr_q, addr_d;
  logic [ADDRESSWIDTH-1:0]  remaining_q, remaining_d;
  logic                     done_q, done_d;
  logic                     fifo_empty, fifo_full, beat_accept;
  logic [DATAWIDTH-1:0]     fifo_data;

  wm_fifo #(
    .DATAWIDTH  (DATAWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (user_write_buffer),
    .data_i  (user_buffer_data),
    .pop_i   (beat_accept),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign master_write      = (state_q == RUN) && !fifo_empty;
  assign beat_accept       = master_write && !master_waitrequest;
  assign master_address    = addr_q;
  assign master_writedata  = fifo_data;
  assign master_byteenable = {BYTEENABLEWIDTH{master_write}};
  assign control_done      = done_q;
  assign user_buffer_full  = fifo_full;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = done_q;
    case (state_q)
      IDLE: begin
        done_d = !control_go;
        if (control_go) begin
          // Sub-word offsets are dropped from both base and length.
          addr_d      = {control_write_base[ADDRESSWIDTH-1:BYTE_SHIFT], {BYTE_SHIFT{1'b0}}};
          remaining_d = {control_write_length[ADDRESSWIDTH-1:BYTE_SHIFT], {BYTE_SHIFT{1'b0}}};
          if (remaining_d != '0) state_d = RUN;
        end
      end
      RUN: begin
        if (beat_accept) begin
          remaining_d = remaining_q - STEP;
          if (!control_fixed_location) addr_d = addr_q + STEP;
          if (remaining_q == STEP) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

`ifdef WRITE_MASTER_BEAT_COUNT_EN
  logic [31:0] beat_count_q;

  always_ff @(posedge clk) begin
    if (!reset)           beat_count_q <= '0;
    else if (beat_accept) beat_count_q <= beat_count_q + 32'd1;
  end

  assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_avalon_write_master.sv
// Bench for avalon_write_master: queue-based transfer model checked every cycle,
// directed scenarios with literal expectations, then randomized transfers.
module tb_avalon_write_master;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int BEW = 4;
  localparam int DEPTH = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           control_fixed_location = 1'b0;
  logic [AW-1:0]  control_write_base = '0;
  logic [AW-1:0]  control_write_length = '0;
  logic           control_go = 1'b0;
  logic           control_done;
  logic           user_write_buffer = 1'b0;
  logic [DW-1:0]  user_buffer_data = '0;
  logic           user_buffer_full;
  logic [AW-1:0]  master_address;
  logic           master_write;
  logic [BEW-1:0] master_byteenable;
  logic [DW-1:0]  master_writedata;
  logic           master_waitrequest = 1'b0;
`ifdef WRITE_MASTER_BEAT_COUNT_EN
  logic [31:0]    beat_count;
`endif

  always #5 clk = ~clk;

  avalon_write_master dut (
    .clk                    (clk),
    .reset                  (reset),
    .control_fixed_location (control_fixed_location),
    .control_write_base     (control_write_base),
    .control_write_length   (control_write_length),
    .control_go             (control_go),
    .control_done           (control_done),
    .user_write_buffer      (user_write_buffer),
    .user_buffer_data       (user_buffer_data),
    .user_buffer_full       (user_buffer_full),
    .master_address         (master_address),
    .master_write           (master_write),
    .master_byteenable      (master_byteenable),
    .master_writedata       (master_writedata),
    .master_waitrequest     (master_waitrequest)
`ifdef WRITE_MASTER_BEAT_COUNT_EN
    ,
    .beat_count             (beat_count)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of buffered words plus the transfer in progress.
  logic [DW-1:0] m_q[$];
  bit            m_busy = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] m_left = '0;
  bit            m_done = 1'b1;
  int unsigned   m_beats = 0;

  always @(posedge clk) begin : model
    bit acc;
    bit was_full;
    if (!reset) begin
      m_q.delete();
      m_busy  = 1'b0;
      m_addr  = '0;
      m_left  = '0;
      m_done  = 1'b1;
      m_beats = 0;
    end else begin
      acc      = m_busy && (m_q.size() > 0) && !master_waitrequest;
      was_full = (m_q.size() == DEPTH);
      if (acc) begin
        void'(m_q.pop_front());
        m_beats++;
        m_left = m_left - AW'(BEW);
        if (!control_fixed_location) m_addr = m_addr + AW'(BEW);
      end
      if (user_write_buffer && !was_full) m_q.push_back(user_buffer_data);
      if (!m_busy) begin
        if (control_go) begin
          m_addr = control_write_base & ~AW'(BEW - 1);
          m_left = control_write_length & ~AW'(BEW - 1);
          m_done = 1'b0;
          m_busy = (m_left != '0);
        end else begin
          m_done = 1'b1;
        end
      end else if (acc && m_left == '0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  end

  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];

  always @(negedge clk) begin : compare
    bit exp_write;
    exp_write = m_busy && (m_q.size() > 0);
    chk("done", control_done, m_done);
    chk("write", master_write, exp_write);
    chk("full", user_buffer_full, m_q.size() == DEPTH);
    if (exp_write) begin
      chk("addr", master_address, m_addr);
      chk("data", master_writedata, m_q[0]);
      chk("byteenable", master_byteenable, 4'hF);
    end
`ifdef WRITE_MASTER_BEAT_COUNT_EN
    chk("beat_count", beat_count, m_beats);
`endif
    if (reset && master_write && !master_waitrequest) begin
      log_addr.push_back(master_address);
      log_data.push_back(master_writedata);
    end
  end

  // 0: never stall, 1: toggle each cycle, 2: random stalls
  int wr_mode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (wr_mode)
      1:       master_waitrequest = ~master_waitrequest;
      2:       master_waitrequest = ($urandom_range(0, 2) == 0);
      default: master_waitrequest = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    user_write_buffer = 1'b1;
    user_buffer_data  = d;
    tick();
    user_write_buffer = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] base, input int unsigned len, input bit fixed);
    control_write_base     = base;
    control_write_length   = AW'(len);
    control_fixed_location = fixed;
    control_go             = 1'b1;
    tick();
    control_go = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (control_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, control_done, 1'b1);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    // 1: reset then idle
    repeat (3) tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("t1_done", control_done, 1'b1);
    chk("t1_write", master_write, 1'b0);
    chk("t1_full", user_buffer_full, 1'b0);

    // 2: single fixed-location beat
    clear_log();
    push_word(32'hAAAA0000);
    start(28'h8000068, 4, 1'b1);
    chk("t2_done_low", control_done, 1'b0);
    chk("t2_write_first", master_write, 1'b1);
    tick();
    chk("t2_done_high", control_done, 1'b1);
    chk("t2_beats", log_addr.size(), 1);
    chk("t2_addr", log_addr[0], 28'h8000068);
    chk("t2_data", log_data[0], 32'hAAAA0000);

    // 3: six incrementing beats under toggling waitrequest
    clear_log();
    for (int i = 1; i <= 6; i++) push_word(DW'(i));
    wr_mode = 1;
    start(28'h8000008, 24, 1'b0);
    wait_done(200, "t3_timeout");
    wr_mode = 0;
    chk("t3_beats", log_addr.size(), 6);
    for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
      chk("t3_addr", log_addr[i], 28'h8000008 + AW'(4 * i));
      chk("t3_data", log_data[i], DW'(i + 1));
    end

    // 4: overfill the FIFO, then drain it with one transfer
    clear_log();
    for (int i = 0; i < 33; i++) push_word(32'h100 + DW'(i));
    chk("t4_full", user_buffer_full, 1'b1);
    start(28'h0001000, 128, 1'b0);
    wait_done(400, "t4_timeout");
    repeat (3) tick();
    chk("t4_beats", log_addr.size(), 32);
    if (log_data.size() == 32) chk("t4_last_data", log_data[31], 32'h11F);
    chk("t4_full_after", user_buffer_full, 1'b0);

    // 5: zero length and sub-word length
    clear_log();
    push_word(32'h55);
    start(28'h0000040, 0, 1'b0);
    chk("t5_len0_done_low", control_done, 1'b0);
    chk("t5_len0_write", master_write, 1'b0);
    tick();
    chk("t5_len0_done_high", control_done, 1'b1);
    chk("t5_len0_beats", log_addr.size(), 0);
    push_word(32'h66);
    start(28'h0000044, 7, 1'b0);
    wait_done(50, "t5_timeout");
    repeat (2) tick();
    chk("t5_len7_beats", log_addr.size(), 1);
    if (log_data.size() > 0) chk("t5_len7_data", log_data[0], 32'h55);

    // 6: reset in the middle of a transfer
    clear_log();
    for (int i = 0; i < 4; i++) push_word(32'h200 + DW'(i));
    start(28'h0000080, 16, 1'b0);
    begin
      int n = 0;
      while (log_addr.size() < 2 && n < 50) begin
        tick();
        n++;
      end
    end
    chk("t6_two_beats", log_addr.size(), 2);
    reset = 1'b0;
    tick();
    chk("t6_write_low", master_write, 1'b0);
    chk("t6_done", control_done, 1'b1);
    chk("t6_full", user_buffer_full, 1'b0);
`ifdef WRITE_MASTER_BEAT_COUNT_EN
    chk("t6_beat_count", beat_count, 32'd0);
`endif
    reset = 1'b1;
    tick();
    clear_log();
    start(28'h0000100, 4, 1'b0);
    chk("t6_flushed_nowrite", master_write, 1'b0);
    push_word(32'h77);
    wait_done(50, "t6_timeout");
    chk("t6_post_data", (log_data.size() == 1) ? log_data[0] : 32'hDEAD, 32'h77);

    // Randomized transfers, including an address wrap case
    for (int t = 0; t < 25; t++) begin
      int n;
      int npre;
      npre = $urandom_range(0, 6);
      for (int k = 0; k < npre; k++) push_word($urandom);
      wr_mode = $urandom_range(0, 2);
      if (t == 0) start(28'hFFFFFF8, 16, 1'b0);
      else start(AW'($urandom), $urandom_range(0, 80), 1'($urandom_range(0, 1)));
      n = 0;
      while (control_done !== 1'b1 && n < 3000) begin
        user_write_buffer = 1'($urandom_range(0, 1));
        user_buffer_data  = $urandom;
        control_go        = (control_done == 1'b0) && ($urandom_range(0, 7) == 0);
        tick();
        n++;
      end
      control_go = 1'b0;
      user_write_buffer = 1'b0;
      chk("rand_done", control_done, 1'b1);
      tick();
    end
    wr_mode = 0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
